led_pwm_driver: RTL and testbench
=================================

Name: led_pwm_driver

Overview:
- Downstream consumer of the 8-bit LED PIO output register on the LogicalStep board.
- Takes the CPU-written LED pattern and drives the physical LED pins.
- Applies a global PWM brightness and a glitch-free, frame-aligned pattern update.
- Lets software dim the VU/status LEDs without CPU-side bit-banging.

Parameters:
- N_LEDS, 8, number of LED outputs; width of pattern_in and led_out.
- PRESCALE, 50, clk cycles per PWM tick; must be ≥1.
- BLINK_FRAMES, 64, PWM frames per blink half-period; used only with LED_BLINK_EN.

Ports:
- clk  in  1  system clock, same domain as PIO.
- reset_n  in  1  asynchronous, active-low reset.
- pattern_in  in  N_LEDS  LED pattern from PIO out_port; 1 = LED on.
- brightness  in  8  duty value; 0 = off, 255 = fully on.
- enable  in  1  driver enable; 0 forces all LEDs off.
- led_out  out  N_LEDS  registered LED pin drive.
- frame_start  out  1  one-cycle pulse at each PWM frame boundary.
- blink_mask  in  N_LEDS  LEDs to blink; present only with LED_BLINK_EN.

Behaviour:
- Reset: led_out=0, frame_start=0, prescaler=0, pwm_cnt=0, shadow_pat=0, shadow_bri=0, state=OFF, blink_phase=0, frame_cnt=0.
- All inputs are synchronous to clk; no synchronizers.
- State OFF:
  - Counters held at 0; led_out=0; frame_start=0.
  - On enable=1: go to RUN next cycle. In that same cycle, latch shadow_pat←pattern_in and shadow_bri←brightness, and pulse frame_start.
- State RUN:
  - Prescaler counts 0..PRESCALE-1. tick=1 when prescaler==PRESCALE-1, then prescaler wraps to 0. With PRESCALE=1, tick every cycle.
  - pwm_cnt is 8 bits and advances on each tick through 0..254, then wraps to 0. Frame = 255 ticks = 255*PRESCALE clk cycles.
  - On the tick where pwm_cnt==254:
    - pwm_cnt←0.
    - shadow_pat and shadow_bri are reloaded from the inputs.
    - frame_start=1 for exactly that next cycle.
  - Input changes mid-frame have no effect until the next frame boundary.
  - led_out (registered) ← shadow_pat & {N_LEDS{pwm_cnt < shadow_bri}}, unsigned compare.
    - brightness=255 → always on.
    - brightness=0 → never on.
    - brightness=k → on for k of 255 ticks.
  - Latency: output reflects the current pwm_cnt/shadow values one clk later.
  - On enable=0: go to OFF next cycle and clear counters. led_out=0 on the following cycle. A partial frame is abandoned and no frame_start is generated.
- Simultaneous enable re-assert and frame boundary: cannot occur, since OFF always takes at least one cycle.
- Asynchronous reset mid-frame: all state returns to reset values immediately; led_out=0 with no glitch beyond the reset edge.

Optional Feature:
- Macro: LED_BLINK_EN.
- Enabled:
  - blink_mask port exists.
  - frame_cnt counts frame boundaries 0..BLINK_FRAMES-1; blink_phase toggles on wrap.
  - blink_mask is latched into a shadow register at the frame boundary.
  - While blink_phase=1, LEDs with shadow blink_mask bit=1 are forced to 0.
  - frame_cnt and blink_phase clear in OFF.
- Disabled:
  - No blink_mask port, frame_cnt or blink_phase logic.
  - led_out equals the PWM-gated pattern only.

Decomposition:
- Package led_drv_pkg:
  - PWM_MAX=8'd254.
  - Default N_LEDS/PRESCALE/BLINK_FRAMES constants.
  - State enum {OFF, RUN}.
- Sub-module led_tick_gen: the prescaler. Parameter PRESCALE; inputs clk, reset_n, clear; output tick. Counter width $clog2(PRESCALE), minimum 1.

Test Plan:
- Reset/idle: assert reset_n=0 mid-run, with enable=1 → led_out=0x00, frame_start=0; after release with enable=0 → led_out stays 0x00 for 1000 cycles.
- Duty: PRESCALE=2, pattern_in=0xA5, brightness=64, enable=1 → per 510-cycle frame, led_out=0xA5 for exactly 128 cycles and 0x00 for 382; frame_start pulses every 510 cycles.
- Extremes: brightness=255 → led_out constant 0xFF for pattern 0xFF. brightness=0 → constant 0x00.
- Shadow update: change pattern_in 0x0F→0xF0 mid-frame → led_out never shows 0xF0 before the cycle after the next frame_start.
- Enable drop: deassert enable at pwm_cnt=100 → led_out=0 within 2 cycles; re-enable → frame_start pulses and a full frame restarts from pwm_cnt=0.
- Blink (LED_BLINK_EN, BLINK_FRAMES=2): pattern_in=0xFF, brightness=255, blink_mask=0x01 → bit0 on for 2 frames and off for 2 frames; bits 7:1 always on.

Source files
------------

// File: rtl/led_drv_pkg.sv
// Shared constants, state encoding and helpers for the LED PWM driver.
// The optional blink feature is enabled by defining LED_BLINK_EN.
package led_drv_pkg;

  localparam logic [7:0] PWM_MAX          = 8'd254;
  localparam int         DEF_N_LEDS       = 8;
  localparam int         DEF_PRESCALE     = 50;
  localparam int         DEF_BLINK_FRAMES = 64;

  typedef enum logic {
    OFF = 1'b0,
    RUN = 1'b1
  } drv_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: asserts tick on the last of every PRESCALE clk cycles.
// clear holds the count at zero so the next frame starts phase-aligned.
module led_tick_gen
  import led_drv_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = cnt_width(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// Frame-aligned PWM LED driver: pattern and brightness are shadowed at frame
// boundaries. Define LED_BLINK_EN to add the blink_mask port and blink logic.
module led_pwm_driver
  import led_drv_pkg::*;
#(
  parameter int N_LEDS   = DEF_N_LEDS,
  parameter int PRESCALE = DEF_PRESCALE
`ifdef LED_BLINK_EN
  ,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_LEDS-1:0] pattern_in,
  input  logic [7:0]        brightness,
  input  logic              enable,
`ifdef LED_BLINK_EN
  input  logic [N_LEDS-1:0] blink_mask,
`endif
  output logic [N_LEDS-1:0] led_out,
  output logic              frame_start
);

  drv_state_t        r_state;
  logic [7:0]        r_pwm_cnt;
  logic [N_LEDS-1:0] r_shadow_pat;
  logic [7:0]        r_shadow_bri;
  logic [N_LEDS-1:0] r_led;
  logic              r_frame_start;

  logic              w_tick;
  logic              w_clear;
  logic              w_start;
  logic              w_frame_end;
  logic              w_load;
  logic              w_on;
  logic [N_LEDS-1:0] w_blank;
  logic [N_LEDS-1:0] w_led_next;

  assign w_clear     = (r_state == OFF) || !enable;
  assign w_start     = (r_state == OFF) && enable;
  assign w_frame_end = (r_state == RUN) && enable && w_tick && (r_pwm_cnt == PWM_MAX);
  assign w_load      = w_start || w_frame_end;
  assign w_on        = (r_pwm_cnt < r_shadow_bri);

  led_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_clear),
    .tick    (w_tick)
  );

`ifdef LED_BLINK_EN
  localparam int            FW     = cnt_width(BLINK_FRAMES);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0]     r_frame_cnt;
  logic              r_blink_phase;
  logic [N_LEDS-1:0] r_shadow_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_shadow_mask <= '0;
    end else begin
      if (w_load) begin
        r_shadow_mask <= blink_mask;
      end
      if (r_state == OFF) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= 1'b0;
      end else if (w_frame_end) begin
        if (r_frame_cnt == F_LAST) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  assign w_blank = r_blink_phase ? r_shadow_mask : '0;
`else
  assign w_blank = '0;
`endif

  for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_led
    assign w_led_next[gi] = r_shadow_pat[gi] & w_on & ~w_blank[gi];
  end

  // Outputs are registered; dropping enable blanks the pins on the next edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= OFF;
      r_pwm_cnt     <= '0;
      r_shadow_pat  <= '0;
      r_shadow_bri  <= '0;
      r_led         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_load;
      if (w_load) begin
        r_shadow_pat <= pattern_in;
        r_shadow_bri <= brightness;
      end
      case (r_state)
        OFF: begin
          r_pwm_cnt <= '0;
          r_led     <= '0;
          if (enable) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            r_state   <= OFF;
            r_pwm_cnt <= '0;
            r_led     <= '0;
          end else begin
            if (w_tick) begin
              r_pwm_cnt <= w_frame_end ? 8'd0 : r_pwm_cnt + 8'd1;
            end
            r_led <= w_led_next;
          end
        end
        default: begin
          r_state   <= OFF;
          r_pwm_cnt <= '0;
          r_led     <= '0;
        end
      endcase
    end
  end

  assign led_out     = r_led;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed scoreboard bench for led_pwm_driver (PRESCALE=2, 510-cycle frames).
`timescale 1ns/1ps
module tb_led_pwm_driver;

  localparam int N     = 8;
  localparam int PS    = 2;
  localparam int FRAME = 255 * PS;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] pattern_in = '0;
  logic [7:0]   brightness = '0;
  logic         enable = 1'b0;
  logic [N-1:0] led_out;
  logic         frame_start;
`ifdef LED_BLINK_EN
  logic [N-1:0] blink_mask = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  led_pwm_driver #(
    .N_LEDS   (N),
    .PRESCALE (PS)
`ifdef LED_BLINK_EN
    ,
    .BLINK_FRAMES (2)
`endif
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pattern_in  (pattern_in),
    .brightness  (brightness),
    .enable      (enable),
`ifdef LED_BLINK_EN
    .blink_mask  (blink_mask),
`endif
    .led_out     (led_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check_obs(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_underflow observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
      $display("check %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  // Advances at least one cycle, then up to budget cycles, until frame_start.
  task automatic wait_fs(input int budget);
    int k = 0;
    step();
    while (frame_start !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    expect_val("frame_start_seen", 1);
    check_obs(32'(frame_start === 1'b1));
  endtask

  // Called on the frame_start cycle; samples one full frame plus the next boundary.
  task automatic measure_frame(input logic [N-1:0] pat, input logic [7:0] bri);
    int on_c  = 0;
    int off_c = 0;
    int oth_c = 0;
    int fs_c  = 0;
    int exp_on;
    exp_on = int'(bri) * PS;
    expect_val("frame_on_cycles", exp_on);
    expect_val("frame_off_cycles", FRAME - exp_on);
    expect_val("frame_other_cycles", 0);
    expect_val("frame_fs_in_window", 1);
    expect_val("frame_period_fs", 1);
    for (int i = 0; i < FRAME; i++) begin
      if (led_out === pat) on_c++;
      else if (led_out === '0) off_c++;
      else oth_c++;
      if (frame_start === 1'b1) fs_c++;
      step();
    end
    check_obs(on_c);
    check_obs(off_c);
    check_obs(oth_c);
    check_obs(fs_c);
    check_obs(32'(frame_start));
  endtask

  task automatic const_frame(input string tag, input logic [N-1:0] exp_led);
    int bad = 0;
    wait_fs(3 * FRAME);
    expect_val(tag, 0);
    step();
    for (int i = 0; i < FRAME; i++) begin
      if (led_out !== exp_led) bad++;
      step();
    end
    check_obs(bad);
  endtask

  initial begin
    int bad;
    int fs_c;
    int k;

    // Reset state
    repeat (3) step();
    expect_val("reset_led", 0);
    check_obs(led_out);
    expect_val("reset_fs", 0);
    check_obs(frame_start);

    // Run, then assert reset asynchronously mid-frame with enable high
    reset_n    = 1'b1;
    pattern_in = 8'hFF;
    brightness = 8'd255;
    enable     = 1'b1;
    step();
    expect_val("enable_start_fs", 1);
    check_obs(frame_start);
    repeat (50) step();
    expect_val("run_led_full", 8'hFF);
    check_obs(led_out);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    expect_val("async_reset_led", 0);
    check_obs(led_out);
    expect_val("async_reset_fs", 0);
    check_obs(frame_start);
    step();
    enable  = 1'b0;
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (led_out !== '0 || frame_start !== 1'b0) bad++;
    end
    expect_val("idle_1000_active", 0);
    check_obs(bad);

    // Duty: 0xA5 at 64/255; a mid-frame brightness change waits for the boundary
    pattern_in = 8'hA5;
    brightness = 8'd64;
    enable     = 1'b1;
    wait_fs(4);
    measure_frame(8'hA5, 8'd64);
    brightness = 8'd200;
    measure_frame(8'hA5, 8'd64);
    measure_frame(8'hA5, 8'd200);

    // Extremes
    pattern_in = 8'hFF;
    brightness = 8'd255;
    const_frame("bri255_bad_cycles", 8'hFF);
    brightness = 8'd0;
    const_frame("bri0_bad_cycles", 8'h00);

    // Shadow update: new pattern must not appear before the next frame
    pattern_in = 8'h0F;
    brightness = 8'd255;
    wait_fs(3 * FRAME);
    repeat (100) step();
    pattern_in = 8'hF0;
    bad = 0;
    k   = 0;
    while (frame_start !== 1'b1 && k < FRAME) begin
      if (led_out !== 8'h0F) bad++;
      step();
      k++;
    end
    if (led_out !== 8'h0F) bad++;
    expect_val("shadow_fs_seen", 1);
    check_obs(32'(frame_start === 1'b1));
    expect_val("shadow_early_cycles", 0);
    check_obs(bad);
    step();
    expect_val("shadow_new_pattern", 8'hF0);
    check_obs(led_out);

    // Enable drop at pwm_cnt=100, then restart from a fresh frame
    repeat (199) step();
    expect_val("pre_drop_led", 8'hF0);
    check_obs(led_out);
    enable = 1'b0;
    step();
    step();
    expect_val("drop_led_2cyc", 0);
    check_obs(led_out);
    fs_c = 0;
    bad  = 0;
    for (int i = 0; i < 20; i++) begin
      if (frame_start === 1'b1) fs_c++;
      if (led_out !== '0) bad++;
      step();
    end
    expect_val("off_fs_pulses", 0);
    check_obs(fs_c);
    expect_val("off_led_active", 0);
    check_obs(bad);
    pattern_in = 8'h3C;
    brightness = 8'd64;
    enable     = 1'b1;
    step();
    expect_val("reenable_fs", 1);
    check_obs(frame_start);
    measure_frame(8'h3C, 8'd64);

`ifdef LED_BLINK_EN
    // Blink with BLINK_FRAMES=2: bit0 on two frames, off two frames
    enable = 1'b0;
    repeat (3) step();
    pattern_in = 8'hFF;
    brightness = 8'd255;
    blink_mask = 8'h01;
    enable     = 1'b1;
    step();
    for (int f = 0; f < 5; f++) begin
      expect_val($sformatf("blink_frame%0d_mid", f), ((f % 4) < 2) ? 8'hFF : 8'hFE);
      repeat (FRAME / 2) step();
      check_obs(led_out);
      wait_fs(FRAME);
    end
`endif

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
